fp8_result_streamer: RTL

Double-buffered output stage downstream of the bf16-to-fp8 converters. It captures one tile of N_ELEMS fp8 results, one per converter lane, in a single load strobe. It then streams the tile out one byte per cycle over an 8-bit valid/ready channel toward the chip output pins. While one tile drains, the next tile can be loaded, so back-to-back tiles leave the output with no idle cycles.

---
 rtl/tpu_pkg.sv | 16 +
 rtl/fp8_result_streamer.sv | 116 +++++++++++
 2 files changed

// File: rtl/tpu_pkg.sv
// Shared TPU datapath definitions.
// Holds the fp8/bf16 widths and the fp8 field layout used by the
// bf16-to-fp8 converters and the result streamer.
package tpu_pkg;

  localparam int unsigned FP8_W  = 8;
  localparam int unsigned BF16_W = 16;

  // fp8 E4M3-style field split, MSB first.
  typedef struct packed {
    logic       sign;
    logic [3:0] exp4;
    logic [2:0] mant3;
  } fp8_t;

endpackage

// File: rtl/fp8_result_streamer.sv
// Double-buffered fp8 result streamer.
// Captures a whole tile of N_ELEMS fp8 lanes in one load strobe into one of
// two banks, then streams it out lane 0 first, one byte per transfer, over a
// valid/ready channel. The second bank can be loaded while the first drains,
// so consecutive tiles leave the output with no idle cycles.
//
// Ports:
//   clk        clock, all state on rising edge
//   rst_n      asynchronous active-low reset
//   load       tile strobe, accepted when load && load_ready
//   in_fp8     packed tile, lane i at [8i+7:8i]
//   load_ready write bank is empty
//   out_valid  out_data holds a valid byte
//   out_data   current fp8 byte (0x00 when not valid)
//   out_last   out_data is the final lane of its tile
//   out_ready  downstream accepts the byte
//   busy       at least one bank holds a tile
//   overflow   sticky: a load was presented while load_ready was low
module fp8_result_streamer
  import tpu_pkg::*;
#(
  parameter int unsigned N_ELEMS = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     load,
  input  logic [FP8_W*N_ELEMS-1:0] in_fp8,
  output logic                     load_ready,
  output logic                     out_valid,
  output logic [FP8_W-1:0]         out_data,
  output logic                     out_last,
  input  logic                     out_ready,
  output logic                     busy,
  output logic                     overflow
);

  localparam int unsigned IDX_W = $clog2(N_ELEMS);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_ELEMS - 1);

  fp8_t [N_ELEMS-1:0] bank_q [2];
  fp8_t [N_ELEMS-1:0] bank_d [2];
  logic [1:0]         full_q, full_d;
  logic               wr_sel_q, wr_sel_d;
  logic               rd_sel_q, rd_sel_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic               ovf_q, ovf_d;

  logic load_acc;
  logic xfer;
  fp8_t lane;

  // Handshake signals derive from registered state only; a bank freed by the
  // drain this cycle is not offered to the loader until the next cycle.
  always_comb begin
    load_ready = !full_q[wr_sel_q];
    out_valid  = full_q[rd_sel_q];
    lane       = bank_q[rd_sel_q][idx_q];
    out_data   = out_valid ? lane : '0;
    out_last   = out_valid && (idx_q == LAST_IDX);
    busy       = |full_q;
    overflow   = ovf_q;
  end

  always_comb begin
    load_acc = load && load_ready;
    xfer     = out_valid && out_ready;

    bank_d   = bank_q;
    full_d   = full_q;
    wr_sel_d = wr_sel_q;
    rd_sel_d = rd_sel_q;
    idx_d    = idx_q;
    ovf_d    = ovf_q;

    if (load_acc) begin
      bank_d[wr_sel_q] = in_fp8;
      full_d[wr_sel_q] = 1'b1;
      wr_sel_d         = ~wr_sel_q;
    end else if (load) begin
      ovf_d = 1'b1;
    end

    // An accepted load always targets an empty bank while the drain clears a
    // full one, so the two full_d updates never hit the same bit.
    if (xfer) begin
      if (idx_q == LAST_IDX) begin
        idx_d            = '0;
        full_d[rd_sel_q] = 1'b0;
        rd_sel_d         = ~rd_sel_q;
      end else begin
        idx_d = idx_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bank_q[0] <= '0;
      bank_q[1] <= '0;
      full_q    <= '0;
      wr_sel_q  <= 1'b0;
      rd_sel_q  <= 1'b0;
      idx_q     <= '0;
      ovf_q     <= 1'b0;
    end else begin
      bank_q[0] <= bank_d[0];
      bank_q[1] <= bank_d[1];
      full_q    <= full_d;
      wr_sel_q  <= wr_sel_d;
      rd_sel_q  <= rd_sel_d;
      idx_q     <= idx_d;
      ovf_q     <= ovf_d;
    end
  end

endmodule
